// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - terminal-style write controller for the text-mode screen RAM
// Interprets a byte stream as a terminal and sequences screen and line clears.
module text_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  input  logic       clear_req,
  output logic       wr_en,
  output logic [7:0] wr_x,
  output logic [6:0] wr_y,
  output logic [7:0] wr_char,
  output logic [7:0] cursor_x,
  output logic [6:0] cursor_y,
  output logic       busy
);

  localparam logic [1:0] S_CLEAR   = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_LINECLR = 2'd2;

  localparam logic [7:0] X_LAST = 8'(COLS - 1);
  localparam logic [6:0] Y_LAST = 7'(ROWS - 1);

  logic [1:0] state_q, state_d;
  // pre_q marks a fill state whose first cell has not been emitted yet
  logic       pre_q, pre_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] cursor_x_q, cursor_x_d;
  logic [6:0] cursor_y_q, cursor_y_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_x_q, wr_x_d;
  logic [6:0] wr_y_q, wr_y_d;
  logic [7:0] wr_char_q, wr_char_d;
  logic       busy_q;
  logic [6:0] next_row;
  logic       accept;

  assign in_ready = (state_q == S_IDLE) && !clear_req;
  assign accept   = in_valid && in_ready;
  assign next_row = (cursor_y_q == Y_LAST) ? 7'd0 : cursor_y_q + 7'd1;

  // Output registers are loaded from next-state values so a fill cell is
  // visible in the same cycle the fill state holds that counter value.
  always_comb begin
    state_d    = state_q;
    pre_d      = 1'b0;
    cx_d       = cx_q;
    cy_d       = cy_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_char_d  = wr_char_q;

    case (state_q)
      S_CLEAR: begin
        if (pre_q) begin
          wr_en_d   = 1'b1;
          wr_x_d    = cx_q;
          wr_y_d    = cy_q;
          wr_char_d = BLANK;
        end else if (cx_q == X_LAST && cy_q == Y_LAST) begin
          state_d    = S_IDLE;
          cursor_x_d = 8'd0;
          cursor_y_d = 7'd0;
        end else begin
          if (cx_q == X_LAST) begin
            cx_d = 8'd0;
            cy_d = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          wr_en_d   = 1'b1;
          wr_x_d    = cx_d;
          wr_y_d    = cy_d;
          wr_char_d = BLANK;
        end
      end

      S_IDLE: begin
        if (clear_req || (accept && in_char == 8'h0C)) begin
          state_d   = S_CLEAR;
          cx_d      = 8'd0;
          cy_d      = 7'd0;
          wr_en_d   = 1'b1;
          wr_x_d    = 8'd0;
          wr_y_d    = 7'd0;
          wr_char_d = BLANK;
        end else if (accept) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_x_d    = cursor_x_q;
            wr_y_d    = cursor_y_q;
            wr_char_d = in_char;
            if (cursor_x_q < X_LAST) begin
              cursor_x_d = cursor_x_q + 8'd1;
            end else begin
              cursor_x_d = 8'd0;
              cursor_y_d = next_row;
              state_d    = S_LINECLR;
              pre_d      = 1'b1;
              cx_d       = 8'd0;
              cy_d       = next_row;
            end
          end else if (in_char == 8'h0A) begin
            cursor_x_d = 8'd0;
            cursor_y_d = next_row;
            state_d    = S_LINECLR;
            cx_d       = 8'd0;
            cy_d       = next_row;
            wr_en_d    = 1'b1;
            wr_x_d     = 8'd0;
            wr_y_d     = next_row;
            wr_char_d  = BLANK;
          end else if (in_char == 8'h0D) begin
            cursor_x_d = 8'd0;
          end else if (in_char == 8'h08 && cursor_x_q != 8'd0) begin
            cursor_x_d = cursor_x_q - 8'd1;
            wr_en_d    = 1'b1;
            wr_x_d     = cursor_x_q - 8'd1;
            wr_y_d     = cursor_y_q;
            wr_char_d  = BLANK;
          end
        end
      end

      S_LINECLR: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          cx_d      = 8'd0;
          cy_d      = 7'd0;
          wr_en_d   = 1'b1;
          wr_x_d    = 8'd0;
          wr_y_d    = 7'd0;
          wr_char_d = BLANK;
        end else if (pre_q) begin
          wr_en_d   = 1'b1;
          wr_x_d    = cx_q;
          wr_y_d    = cy_q;
          wr_char_d = BLANK;
        end else if (cx_q == X_LAST) begin
          state_d = S_IDLE;
        end else begin
          cx_d      = cx_q + 8'd1;
          wr_en_d   = 1'b1;
          wr_x_d    = cx_d;
          wr_y_d    = cy_q;
          wr_char_d = BLANK;
        end
      end

      default: begin
        state_d = S_CLEAR;
        pre_d   = 1'b1;
        cx_d    = 8'd0;
        cy_d    = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      pre_q      <= 1'b1;
      cx_q       <= 8'd0;
      cy_q       <= 7'd0;
      cursor_x_q <= 8'd0;
      cursor_y_q <= 7'd0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= 8'd0;
      wr_y_q     <= 7'd0;
      wr_char_q  <= 8'd0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_char_q  <= wr_char_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_char  = wr_char_q;
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - directed self-checking bench for text_console_ctrl
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;
  logic       clear_req = 1'b0;
  logic       wr_en;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_char;
  logic [7:0] cursor_x;
  logic [6:0] cursor_y;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  text_console_ctrl #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .clear_req(clear_req), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_char(wr_char), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Samples each cycle until in_ready; fill order is row-major for row<0, else a single row.
  task automatic collect(input int row, input int maxc, output int n, output int bad,
                         output int cyc, output int lx, output int ly);
    int ex, ey;
    n = 0; bad = 0; cyc = 0; lx = -1; ly = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (in_ready) break;
      cyc++;
      if (wr_en) begin
        ex = (row < 0) ? n % 80 : n;
        ey = (row < 0) ? n / 80 : row;
        if (int'(wr_x) != ex || int'(wr_y) != ey || wr_char != 8'h20) bad++;
        lx = int'(wr_x);
        ly = int'(wr_y);
        n++;
      end
    end
  endtask

  task automatic full_clear(input string tag);
    int n, bad, cyc, lx, ly;
    collect(-1, 3000, n, bad, cyc, lx, ly);
    check({tag, "_writes"}, n, 2400);
    check({tag, "_order"}, bad, 0);
    check({tag, "_last_x"}, lx, 79);
    check({tag, "_last_y"}, ly, 29);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cursor"}, {cursor_x, 1'b0, cursor_y}, 16'h0000);
  endtask

  task automatic line_feed(input int row);
    int n, bad, cyc, lx, ly;
    send(8'h0A);
    collect(row, 200, n, bad, cyc, lx, ly);
    check("lf_writes", n, 80);
    check("lf_order", bad, 0);
    check("lf_cycles", cyc, 80);
    check("lf_cursor", {cursor_x, 1'b0, cursor_y}, {8'd0, 1'b0, 7'(row)});
  endtask

  task automatic check_write(input string tag, input int x, input int y, input logic [7:0] c);
    check({tag, "_en"}, wr_en, 1);
    check({tag, "_xy"}, {wr_x, 1'b0, wr_y}, {8'(x), 1'b0, 7'(y)});
    check({tag, "_char"}, wr_char, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, cyc, lx, ly;

    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", in_ready, 0);
    check("rst_wr", {wr_x, wr_y, wr_char}, 0);
    check("rst_cursor", {cursor_x, 1'b0, cursor_y}, 0);
    rst_n = 1'b1;
    full_clear("boot");

    // Back-to-back "AB" from home
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'h41;
    @(posedge clk);
    #1 in_char = 8'h42;
    @(negedge clk);
    check_write("a", 0, 0, 8'h41);
    check("ab_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_write("b", 1, 0, 8'h42);
    check("ab_cursor", {cursor_x, 1'b0, cursor_y}, {8'd2, 8'd0});

    // End-of-row wrap from 79/3
    send(8'h0D);
    for (int r = 1; r <= 3; r++) line_feed(r);
    for (int i = 0; i < 79; i++) send(8'h61);
    @(negedge clk);
    check("pre_z_cursor", {cursor_x, 1'b0, cursor_y}, {8'd79, 8'd3});
    send(8'h5A);
    @(negedge clk);
    check_write("z", 79, 3, 8'h5A);
    check("z_ready_low", in_ready, 0);
    collect(4, 200, n, bad, cyc, lx, ly);
    check("z_lineclr_writes", n, 80);
    check("z_lineclr_order", bad, 0);
    check("z_busy_cycles", cyc, 80);
    check("z_cursor", {cursor_x, 1'b0, cursor_y}, {8'd0, 8'd4});

    // LF on the last row wraps to row 0
    for (int r = 5; r <= 29; r++) line_feed(r);
    for (int i = 0; i < 5; i++) send(8'h62);
    line_feed(0);

    // BS, CR, BS at column 0, ignored byte
    line_feed(1);
    line_feed(2);
    for (int i = 0; i < 3; i++) send(8'h63);
    send(8'h08);
    @(negedge clk);
    check_write("bs", 2, 2, 8'h20);
    check("bs_cursor", {cursor_x, 1'b0, cursor_y}, {8'd2, 8'd2});
    send(8'h0D);
    @(negedge clk);
    check("cr_no_write", wr_en, 0);
    check("cr_cursor", {cursor_x, 1'b0, cursor_y}, {8'd0, 8'd2});
    send(8'h08);
    @(negedge clk);
    check("bs0_no_write", wr_en, 0);
    check("bs0_cursor", {cursor_x, 1'b0, cursor_y}, {8'd0, 8'd2});
    send(8'h07);
    @(negedge clk);
    check("bel_no_write", wr_en, 0);
    check("bel_ready", in_ready, 1);
    check("bel_cursor", {cursor_x, 1'b0, cursor_y}, {8'd0, 8'd2});

    // clear_req beats a simultaneous byte
    @(negedge clk);
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_char   = 8'h51;
    #1 check("clr_blocks_ready", in_ready, 0);
    @(posedge clk);
    #1 clear_req = 1'b0;
    in_valid = 1'b0;
    full_clear("clrreq");

    // Asynchronous reset during a line clear
    send(8'h0A);
    repeat (10) @(negedge clk);
    check("mid_lineclr_wr", wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_busy", busy, 1);
    check("async_wr", {wr_x, wr_y, wr_char}, 0);
    check("async_cursor", {cursor_x, 1'b0, cursor_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    full_clear("rerst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
